// File: rtl/bcd_digit_encoder.sv
// bcd_digit_encoder
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Produces four BCD digits (thousands..ones) for the seven-segment driver.
// The digit and ovf outputs only change on the cycle a conversion completes,
// so the display never shows a partially converted value.
module bcd_digit_encoder #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999,
  parameter bit AUTO    = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       d_thou,
  output logic [3:0]       d_hund,
  output logic [3:0]       d_tens,
  output logic [3:0]       d_ones
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // True when the raw input lies above the display limit.
  function automatic logic over_limit(input logic [BIN_W-1:0] v);
    return (32'(v) > 32'(MAX_VAL));
  endfunction

  // Saturate the raw input to the display limit. When BIN_W is small
  // enough that the input can never exceed MAX_VAL this is a pass-through.
  function automatic logic [BIN_W-1:0] clamp_val(input logic [BIN_W-1:0] v);
    if (over_limit(v)) begin
      return BIN_W'(MAX_VAL);
    end
    return v;
  endfunction

  // Add-3 correction: every nibble of 5 or more gets 3 added so that the
  // following left shift carries correctly into the next decimal digit.
  // Clamping keeps every nibble at or below 9, so no nibble overflows.
  function automatic logic [15:0] add3_all(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int n = 0; n < 4; n++) begin
      if (s[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = s[4*n +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_last;
  logic               r_ovf_pend;
  logic [BIN_W-1:0]   r_shift;
  logic [15:0]        r_scratch;
  logic               w_trigger;
  logic [15:0]        w_adj;
  logic               w_load;

  // Conversion request: explicit start, or (in AUTO mode) a new input value.
  always_comb begin
    w_trigger = start | (AUTO & (bin_in != r_last));
    w_load    = (r_state == S_IDLE) & w_trigger;
    w_adj     = add3_all(r_scratch);
  end

  // Control FSM with registered busy/done/ovf/digit outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= '0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      d_thou     <= 4'd0;
      d_hund     <= 4'd0;
      d_tens     <= 4'd0;
      d_ones     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_last     <= bin_in;
            r_ovf_pend <= over_limit(bin_in);
            r_cnt      <= '0;
            busy       <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          d_thou  <= r_scratch[15:12];
          d_hund  <= r_scratch[11:8];
          d_tens  <= r_scratch[7:4];
          d_ones  <= r_scratch[3:0];
          ovf     <= r_ovf_pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: load the clamped value, then correct-and-shift one bit per cycle.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_shift   <= clamp_val(bin_in);
      r_scratch <= 16'd0;
    end else if (r_state == S_SHIFT) begin
      {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
    end
  end

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Directed testbench for bcd_digit_encoder (default instance plus an AUTO instance).
module tb_bcd_digit_encoder;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = 14'd0;
  logic        busy, done, ovf;
  logic [3:0]  d_thou, d_hund, d_tens, d_ones;

  logic        start_a = 1'b0;
  logic [13:0] bin_a = 14'd0;
  logic        busy_a, done_a, ovf_a;
  logic [3:0]  a_thou, a_hund, a_tens, a_ones;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  bcd_digit_encoder #(.BIN_W(14), .MAX_VAL(9999), .AUTO(1'b0)) dut (
    .clk(clk), .clr(clr), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .ovf(ovf),
    .d_thou(d_thou), .d_hund(d_hund), .d_tens(d_tens), .d_ones(d_ones)
  );

  bcd_digit_encoder #(.BIN_W(14), .MAX_VAL(9999), .AUTO(1'b1)) dut_a (
    .clk(clk), .clr(clr), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .d_thou(a_thou), .d_hund(a_hund), .d_tens(a_tens), .d_ones(a_ones)
  );

  function automatic logic [15:0] digits();
    return {d_thou, d_hund, d_tens, d_ones};
  endfunction

  // Pulse start with value v; return done latency, busy cycles and whether
  // the digits moved before done.
  task automatic do_conv(input logic [13:0] v, output int lat, output int nbusy,
                         output logic chg);
    logic [15:0] snap;
    snap   = digits();
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    nbusy = 0;
    chg   = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      if (busy) nbusy++;
      if (digits() !== snap) chg = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #5 clr = 1'b1;
    #1;
    checks++;
    if ({busy, done, ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/ovf=%b expected 000", {busy, done, ovf});
    end
    checks++;
    if (digits() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_digits: got %h expected 0000", digits());
    end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, nb;
    logic chg;
    do_conv(14'd1234, lat, nb, chg);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 15", lat);
    end
    checks++;
    if (nb !== 15) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected 15", nb);
    end
    checks++;
    if (chg !== 1'b0) begin
      errors++;
      $display("FAIL basic_digits_stable: digits changed before done");
    end
    checks++;
    if (digits() !== 16'h1234 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %h ovf=%b expected 1234 ovf=0", digits(), ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || digits() !== 16'h1234) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b digits=%h expected 0/1234", done, digits());
    end
  endtask

  task automatic test_values();
    logic [13:0] vin [3]  = '{14'd9999, 14'd0, 14'd10};
    logic [15:0] vexp [3] = '{16'h9999, 16'h0000, 16'h0010};
    int lat, nb;
    logic chg;
    for (int i = 0; i < 3; i++) begin
      do_conv(vin[i], lat, nb, chg);
      checks++;
      if (lat !== 15 || digits() !== vexp[i] || ovf !== 1'b0) begin
        errors++;
        $display("FAIL values_%0d: lat=%0d digits=%h ovf=%b expected 15/%h/0",
                 vin[i], lat, digits(), ovf, vexp[i]);
      end
    end
  endtask

  task automatic test_clamp();
    int lat, nb;
    logic chg;
    do_conv(14'd12000, lat, nb, chg);
    checks++;
    if (digits() !== 16'h9999 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL clamp_12000: got %h ovf=%b expected 9999 ovf=1", digits(), ovf);
    end
    do_conv(14'd42, lat, nb, chg);
    checks++;
    if (digits() !== 16'h0042 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clamp_then_42: got %h ovf=%b expected 0042 ovf=0", digits(), ovf);
    end
    do_conv(14'd10000, lat, nb, chg);
    checks++;
    if (digits() !== 16'h9999 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL clamp_10000: got %h ovf=%b expected 9999 ovf=1", digits(), ovf);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    bin_in = 14'd500;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin_in = 14'd777;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL busy_ignore_count: got %0d done pulses expected 1", ndone);
    end
    checks++;
    if (digits() !== 16'h0500) begin
      errors++;
      $display("FAIL busy_ignore_result: got %h expected 0500", digits());
    end
  endtask

  task automatic test_abort();
    int ndone;
    bin_in = 14'd8765;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || digits() !== 16'h0000) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b digits=%h expected 0/0/0000",
               busy, done, digits());
    end
    @(negedge clk);
    clr   = 1'b0;
    ndone = 0;
    for (int j = 0; j < 30; j++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses busy=%b expected 0/0", ndone, busy);
    end
  endtask

  task automatic test_auto();
    int ndone;
    bin_a = 14'd5;
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    checks++;
    if (ndone !== 1 || {a_thou, a_hund, a_tens, a_ones} !== 16'h0005) begin
      errors++;
      $display("FAIL auto_5: pulses=%0d digits=%h expected 1/0005",
               ndone, {a_thou, a_hund, a_tens, a_ones});
    end
    bin_a = 14'd6;
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    checks++;
    if (ndone !== 1 || {a_thou, a_hund, a_tens, a_ones} !== 16'h0006 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL auto_6: pulses=%0d digits=%h ovf=%b expected 1/0006/0",
               ndone, {a_thou, a_hund, a_tens, a_ones}, ovf_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_clamp();
    test_busy_ignore();
    test_abort();
    test_auto();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
